ctx_stack: RTL and testbench

Hardware return stack for the MiniRISC CPU v2.0 control unit. It holds the program counter, the four ALU flags and the interrupt-enable bit on subroutine calls and interrupt entry. On return it restores them, driving the flag write port of the ALU (`flag_din`/`flag_wr`) and the control unit's PC-load and IE-load inputs. It replaces any data-memory-based context save, so CALL/RTS/RTI need no bus cycles.

---
 rtl/ctx_stack.sv | 126 ++++++++++++
 tb/tb_ctx_stack.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ctx_stack.sv
// Hardware return stack for the MiniRISC control unit: saves {ie, flags, pc}
// on CALL/IRQ entry and restores them on RTS/RTI with one-cycle load pulses.
module ctx_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PC_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       pop_rti,
  input  logic                       clr,
  input  logic [PC_W-1:0]            pc_in,
  input  logic [3:0]                 flags_in,
  input  logic                       ie_in,
  output logic [PC_W-1:0]            pc_out,
  output logic                       pc_load,
  output logic [3:0]                 flag_dout,
  output logic                       flag_wr,
  output logic                       ie_out,
  output logic                       ie_wr,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = PC_W + 5;

  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  top;
  logic [EW-1:0]  wr_data;
  logic [AW-1:0]  top_idx;
  logic [AW-1:0]  wr_idx;
  logic           wr_en;
  logic           rd_en;
  logic           set_ovf;
  logic           set_unf;
  logic [LW-1:0]  level_nxt;

  assign empty   = (level == LW'(0));
  assign full    = (level == LW'(DEPTH));
  assign top_idx = AW'(level - LW'(1));
  assign top     = mem[top_idx];
  assign wr_data = {ie_in, flags_in, pc_in};

  // Event decode in priority order: clear, replace, push, pop.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = AW'(level);
    rd_en     = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    level_nxt = level;
    if (clr) begin
      level_nxt = LW'(0);
    end else if (push && pop && !empty) begin
      rd_en  = 1'b1;
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      if (pop) begin
        set_unf = 1'b1;
      end
      if (full) begin
        set_ovf = 1'b1;
      end else begin
        wr_en     = 1'b1;
        level_nxt = level + LW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        set_unf = 1'b1;
      end else begin
        rd_en     = 1'b1;
        level_nxt = level - LW'(1);
      end
    end
  end

  // Entry storage carries no reset; only slots below level are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      level <= level_nxt;
      ovf   <= clr ? 1'b0 : (ovf | set_ovf);
      unf   <= clr ? 1'b0 : (unf | set_unf);
    end
  end

  // Restore outputs: PC on every accepted pop, flags/IE only on RTI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out    <= '0;
      pc_load   <= 1'b0;
      flag_dout <= '0;
      flag_wr   <= 1'b0;
      ie_out    <= 1'b0;
      ie_wr     <= 1'b0;
    end else begin
      pc_load <= rd_en;
      flag_wr <= rd_en & pop_rti;
      ie_wr   <= rd_en & pop_rti;
      if (rd_en) begin
        pc_out <= top[PC_W-1:0];
      end
      if (rd_en && pop_rti) begin
        flag_dout <= top[PC_W+3:PC_W];
        ie_out    <= top[EW-1];
      end
    end
  end

endmodule

// File: tb/tb_ctx_stack.sv
// Directed bench for ctx_stack (DEPTH=16, PC_W=8) with hand-computed expectations.
module tb_ctx_stack;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       pop_rti = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] pc_in = '0;
  logic [3:0] flags_in = '0;
  logic       ie_in = 1'b0;
  logic [7:0] pc_out;
  logic       pc_load;
  logic [3:0] flag_dout;
  logic       flag_wr;
  logic       ie_out;
  logic       ie_wr;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       ovf;
  logic       unf;

  int n_vec = 0;
  int n_err = 0;

  ctx_stack #(.DEPTH(16), .PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .pop_rti(pop_rti),
    .clr(clr), .pc_in(pc_in), .flags_in(flags_in), .ie_in(ie_in),
    .pc_out(pc_out), .pc_load(pc_load), .flag_dout(flag_dout),
    .flag_wr(flag_wr), .ie_out(ie_out), .ie_wr(ie_wr), .empty(empty),
    .full(full), .level(level), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then leave the bench 1 ns past the edge.
  task automatic step(input logic ps, input logic pp, input logic rti, input logic cl,
                      input logic [7:0] pc, input logic [3:0] fl, input logic ie);
    push = ps; pop = pp; pop_rti = rti; clr = cl;
    pc_in = pc; flags_in = fl; ie_in = ie;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; pop_rti = 1'b0; clr = 1'b0;
  endtask

  task automatic pulses(input string tag, input logic pl, input logic fw, input logic iw);
    check({tag, "_pc_load"}, 16'(pc_load), 16'(pl));
    check({tag, "_flag_wr"}, 16'(flag_wr), 16'(fw));
    check({tag, "_ie_wr"},   16'(ie_wr),   16'(iw));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 16'(level), 16'd0);
    check("rst_empty", 16'(empty), 16'd1);
    check("rst_full",  16'(full),  16'd0);
    check("rst_ovf",   16'(ovf),   16'd0);
    check("rst_unf",   16'(unf),   16'd0);
    check("rst_pc",    16'(pc_out), 16'd0);
    check("rst_flag",  16'(flag_dout), 16'd0);
    check("rst_ie",    16'(ie_out), 16'd0);
    pulses("rst", 1'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push then RTI pop
    step(1, 0, 0, 0, 8'h12, 4'hA, 1'b1);
    check("p1_level", 16'(level), 16'd1);
    pulses("p1", 1'b0, 1'b0, 1'b0);
    step(0, 1, 1, 0, 8'h00, 4'h0, 1'b0);
    check("rti1_pc",   16'(pc_out), 16'h12);
    check("rti1_flag", 16'(flag_dout), 16'hA);
    check("rti1_ie",   16'(ie_out), 16'd1);
    pulses("rti1", 1'b1, 1'b1, 1'b1);
    check("rti1_level", 16'(level), 16'd0);
    check("rti1_empty", 16'(empty), 16'd1);
    step(0, 0, 0, 0, 8'h00, 4'h0, 1'b0);
    pulses("idle1", 1'b0, 1'b0, 1'b0);
    check("idle1_pc", 16'(pc_out), 16'h12);

    // Fill to DEPTH, overflow, then drain with RTS pops
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, 0, 8'(i), 4'(i), 1'b0);
      if (i == 8) check("fill_half_level", 16'(level), 16'd8);
    end
    check("full_flag",  16'(full),  16'd1);
    check("full_level", 16'(level), 16'd16);
    check("full_ovf0",  16'(ovf),   16'd0);
    step(1, 0, 0, 0, 8'h11, 4'h0, 1'b0);
    check("ovf_set",   16'(ovf),   16'd1);
    check("ovf_level", 16'(level), 16'd16);
    for (int i = 16; i >= 1; i--) begin
      step(0, 1, 0, 0, 8'h00, 4'h0, 1'b0);
      check($sformatf("drain%0d_pc", i), 16'(pc_out), 16'(i));
      pulses($sformatf("drain%0d", i), 1'b1, 1'b0, 1'b0);
      check($sformatf("drain%0d_flag", i), 16'(flag_dout), 16'hA);
      check($sformatf("drain%0d_level", i), 16'(level), 16'(i - 1));
    end
    check("drain_empty", 16'(empty), 16'd1);
    check("drain_ovf_sticky", 16'(ovf), 16'd1);

    // Underflow and clear
    step(0, 1, 1, 0, 8'h00, 4'h0, 1'b0);
    pulses("unf", 1'b0, 1'b0, 1'b0);
    check("unf_set", 16'(unf), 16'd1);
    check("unf_pc_hold", 16'(pc_out), 16'h01);
    check("unf_level", 16'(level), 16'd0);
    step(0, 0, 0, 1, 8'h00, 4'h0, 1'b0);
    check("clr_unf", 16'(unf), 16'd0);
    check("clr_ovf", 16'(ovf), 16'd0);

    // Replace at level 3
    step(1, 0, 0, 0, 8'h10, 4'h0, 1'b0);
    step(1, 0, 0, 0, 8'h20, 4'h0, 1'b0);
    step(1, 0, 0, 0, 8'h30, 4'h0, 1'b0);
    step(1, 1, 0, 0, 8'h40, 4'h0, 1'b0);
    check("repl_pc", 16'(pc_out), 16'h30);
    check("repl_level", 16'(level), 16'd3);
    pulses("repl", 1'b1, 1'b0, 1'b0);
    step(0, 1, 0, 0, 8'h00, 4'h0, 1'b0);
    check("repl_next_pc", 16'(pc_out), 16'h40);
    step(0, 1, 0, 0, 8'h00, 4'h0, 1'b0);
    check("repl_next2_pc", 16'(pc_out), 16'h20);
    step(0, 0, 0, 1, 8'h00, 4'h0, 1'b0);
    check("clr_flush", 16'(level), 16'd0);
    check("clr_nopulse", 16'(pc_load), 16'd0);

    // Push and pop together on an empty stack acts as a push plus underflow
    step(1, 1, 1, 0, 8'h55, 4'h3, 1'b1);
    check("pe_level", 16'(level), 16'd1);
    check("pe_unf", 16'(unf), 16'd1);
    pulses("pe", 1'b0, 1'b0, 1'b0);
    step(0, 1, 1, 0, 8'h00, 4'h0, 1'b0);
    check("pe_pop_pc", 16'(pc_out), 16'h55);
    check("pe_pop_flag", 16'(flag_dout), 16'h3);
    step(0, 0, 0, 1, 8'h00, 4'h0, 1'b0);

    // Interleaved RTS and IRQ contexts
    step(1, 0, 0, 0, 8'h20, 4'h0, 1'b1);
    step(1, 0, 0, 0, 8'h21, 4'h5, 1'b0);
    step(0, 1, 1, 0, 8'h00, 4'h0, 1'b0);
    check("il_rti_pc", 16'(pc_out), 16'h21);
    check("il_rti_flag", 16'(flag_dout), 16'h5);
    check("il_rti_ie", 16'(ie_out), 16'd0);
    pulses("il_rti", 1'b1, 1'b1, 1'b1);
    step(0, 1, 0, 0, 8'h00, 4'h0, 1'b0);
    check("il_rts_pc", 16'(pc_out), 16'h20);
    check("il_rts_flag_hold", 16'(flag_dout), 16'h5);
    check("il_rts_ie_hold", 16'(ie_out), 16'd0);
    pulses("il_rts", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with pulses high and pop pending
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 8'(8'h60 + i), 4'hF, 1'b1);
    step(0, 1, 1, 0, 8'h00, 4'h0, 1'b0);
    check("ar_pre_level", 16'(level), 16'd5);
    pulses("ar_pre", 1'b1, 1'b1, 1'b1);
    check("ar_pre_pc", 16'(pc_out), 16'h65);
    pop = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    pulses("ar", 1'b0, 1'b0, 1'b0);
    check("ar_level", 16'(level), 16'd0);
    check("ar_pc", 16'(pc_out), 16'd0);
    check("ar_flag", 16'(flag_dout), 16'd0);
    check("ar_ie", 16'(ie_out), 16'd0);
    check("ar_empty", 16'(empty), 16'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    pop = 1'b0;
    @(posedge clk); #1;
    check("ar_rel_level", 16'(level), 16'd0);
    pulses("ar_rel", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
